// File: rtl/dphy_lane_aligner.sv
// dphy_lane_aligner: per-lane HS sync hunt, per-lane skew FIFOs and
// lane-aligned word output for a multi-lane D-PHY receiver.
module dphy_lane_aligner #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned SKEW_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hB8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*LANES-1:0]   lane_data,
    input  logic [LANES-1:0]     lane_valid,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_valid,
    output logic                 out_sot,
    output logic                 out_eot,
    output logic                 err_sync,
    output logic                 busy
);

    localparam int unsigned AW = $clog2(SKEW_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = 8;
    localparam int unsigned DW = 8 * LANES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        ALIGNED = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [LANES-1:0] synced;
    logic [LANES-1:0] synced_next;
    logic [LANES-1:0] detect;
    logic [LANES-1:0] wr_req;
    logic [LANES-1:0] wr_en;
    logic [LANES-1:0] full;
    logic [LANES-1:0] empty;
    logic [LANES-1:0] overflow;

    logic [PW-1:0]    wr_ptr [LANES];
    logic [PW-1:0]    rd_ptr [LANES];
    logic [7:0]       mem    [LANES][SKEW_DEPTH];
    logic [DW-1:0]    head;

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             started;
    logic             started_next;

    logic             accept;
    logic             pop;
    logic             any_ovf;
    logic             all_sync_next;
    logic             timeout;
    logic             eob;
    logic             fifo_clr;

    logic [DW-1:0]    out_data_next;
    logic             out_valid_next;
    logic             out_sot_next;
    logic             out_eot_next;
    logic             err_sync_next;
    logic             busy_next;

    // Per-lane sync detection, write request, FIFO status and head byte
    always_comb begin
        detect = '0;
        wr_req = '0;
        full   = '0;
        empty  = '0;
        head   = '0;
        for (int n = 0; n < LANES; n++) begin
            detect[n] = lane_valid[n] && !synced[n] && (lane_data[8*n +: 8] == SYNC_BYTE);
            wr_req[n] = accept && lane_valid[n] && synced[n];
            empty[n]  = (wr_ptr[n] == rd_ptr[n]);
            full[n]   = (wr_ptr[n][AW] != rd_ptr[n][AW]) &&
                        (wr_ptr[n][AW-1:0] == rd_ptr[n][AW-1:0]);
            head[8*n +: 8] = mem[n][rd_ptr[n][AW-1:0]];
        end
    end

    // Burst-level qualifiers; a simultaneous pop frees the slot a full FIFO is written into
    assign accept        = (state == HUNT) || (state == ALIGNED);
    assign pop           = (state == ALIGNED) && (empty == '0);
    assign overflow      = wr_req & full & {LANES{!pop}};
    assign wr_en         = wr_req & ~overflow;
    assign any_ovf       = |overflow;
    assign all_sync_next = &(synced | detect);
    assign timeout       = (state == HUNT) && (({1'b0, cnt} + 9'd1) == 9'(TIMEOUT));
    assign eob           = (state == ALIGNED) && (lane_valid == '0) && (|empty);
    assign fifo_clr      = (state_next == IDLE) || (state_next == FLUSH);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; overflow beats everything, sync beats timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|detect) begin
                    state_next = all_sync_next ? ALIGNED : HUNT;
                end
            end
            HUNT: begin
                if (any_ovf) begin
                    state_next = FLUSH;
                end else if (all_sync_next) begin
                    state_next = ALIGNED;
                end else if (timeout) begin
                    state_next = FLUSH;
                end
            end
            ALIGNED: begin
                if (any_ovf) begin
                    state_next = FLUSH;
                end else if (eob) begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                if (lane_valid == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and control next values
    always_comb begin
        synced_next    = synced | detect;
        cnt_next       = cnt;
        started_next   = started;
        out_data_next  = out_data;
        out_valid_next = pop;
        out_sot_next   = pop && !started;
        out_eot_next   = eob && !any_ovf;
        err_sync_next  = any_ovf || (timeout && !all_sync_next);
        busy_next      = (state_next != IDLE);

        // Flags drop on return to IDLE; FLUSH forces them set so nothing re-hunts mid-burst
        if (state_next == IDLE) begin
            synced_next = '0;
        end else if (state_next == FLUSH) begin
            synced_next = '1;
        end

        case (state)
            IDLE:    cnt_next = '0;
            HUNT:    cnt_next = cnt + CW'(1);
            default: cnt_next = cnt;
        endcase

        if (pop) begin
            out_data_next = head;
            started_next  = 1'b1;
        end
        if (fifo_clr) begin
            started_next = 1'b0;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            synced    <= '0;
            cnt       <= '0;
            started   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sot   <= 1'b0;
            out_eot   <= 1'b0;
            err_sync  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            synced    <= synced_next;
            cnt       <= cnt_next;
            started   <= started_next;
            out_data  <= out_data_next;
            out_valid <= out_valid_next;
            out_sot   <= out_sot_next;
            out_eot   <= out_eot_next;
            err_sync  <= err_sync_next;
            busy      <= busy_next;
        end
    end

    // Skew FIFO pointers, cleared at end of burst and on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < LANES; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
            end
        end else begin
            for (int n = 0; n < LANES; n++) begin
                if (fifo_clr) begin
                    wr_ptr[n] <= '0;
                    rd_ptr[n] <= '0;
                end else begin
                    if (wr_en[n]) begin
                        wr_ptr[n] <= wr_ptr[n] + PW'(1);
                    end
                    if (pop) begin
                        rd_ptr[n] <= rd_ptr[n] + PW'(1);
                    end
                end
            end
        end
    end

    // Skew FIFO storage
    always_ff @(posedge clk) begin
        for (int n = 0; n < LANES; n++) begin
            if (wr_en[n]) begin
                mem[n][wr_ptr[n][AW-1:0]] <= lane_data[8*n +: 8];
            end
        end
    end

endmodule
